// File: rtl/d_ff1.sv
// Positive-edge D flip-flop, WIDTH bits wide, with an asynchronous active-low clear to RESET_VALUE.
// A leaf storage cell: there is no combinational path from D to Q.
`timescale 1ns/1ps

module d_ff1 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             nReset
);

  // An edge where nReset is still low loads RESET_VALUE. If nReset is released
  // on a clock edge, this edge therefore still applies the reset.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_d_ff1.sv
// Bench for d_ff1: a 1-bit and an 8-bit (reset value A5) instance share the clock and reset.
// Directed checks use literal values; a randomized phase compares both instances with a reference model.
`timescale 1ns/1ps

module tb_d_ff1;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       CLK = 1'b0;
  logic       nReset;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  // Values the model expects after the next rising edge
  logic       exp1;
  logic [7:0] exp8;
  logic       cmp_en = 1'b0;

  d_ff1 u1 (
    .Q(q1), .D(d1), .CLK(CLK), .nReset(nReset)
  );

  d_ff1 #(.WIDTH(8), .RESET_VALUE(RV8)) u8 (
    .Q(q8), .D(d8), .CLK(CLK), .nReset(nReset)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic chk_both(input string name, input logic r1, input logic [7:0] r8);
    chk({name, "_w1"}, {7'd0, q1}, {7'd0, r1});
    chk({name, "_w8"}, q8, r8);
  endtask

  // Compare process: 1 ps after every rising edge during the random phase
  always @(posedge CLK) begin
    if (cmp_en) begin
      #0.001;
      chk_both("model", exp1, exp8);
    end
  end

  initial begin
    nReset = 1'b1;
    d1     = 1'b0;
    d8     = 8'h00;

    // Asynchronous assertion with no clock edge yet
    #1 nReset = 1'b0;
    #0.5 chk_both("async_assert", 1'b0, RV8);

    // Held reset blocks capture for several edges
    @(negedge CLK);
    d1 = 1'b1;
    d8 = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #0.001 chk_both("held_reset", 1'b0, RV8);
    end

    // Release between edges: Q holds the reset value until the next rising edge
    #2 nReset = 1'b1;
    #0.001 chk_both("release_midcycle", 1'b0, RV8);
    @(posedge CLK);
    #0.001 chk_both("capture_after_release", 1'b1, 8'h3C);

    // Capture 0 and then capture 1 again
    @(negedge CLK);
    d1 = 1'b0;
    d8 = 8'h5A;
    @(posedge CLK);
    #0.001 chk_both("capture_0", 1'b0, 8'h5A);
    @(negedge CLK);
    d1 = 1'b1;
    d8 = 8'hC3;
    @(posedge CLK);
    #0.001 chk_both("capture_1", 1'b1, 8'hC3);

    // D changing between edges does not disturb Q
    @(negedge CLK);
    d1 = 1'b0;
    d8 = 8'h00;
    #1 chk_both("d_change_no_effect", 1'b1, 8'hC3);
    d1 = 1'b1;
    d8 = 8'hC3;

    // 20 ps clear pulse starting 20 ps after a rising edge
    @(posedge CLK);
    #0.020 nReset = 1'b0;
    #0.020 nReset = 1'b1;
    #0.001 chk_both("async_pulse", 1'b0, RV8);

    // Release coincident with a rising edge: reset still wins on that edge.
    // A nonblocking release lands after the flop has evaluated the edge.
    @(negedge CLK);
    nReset = 1'b0;
    d1     = 1'b1;
    d8     = 8'h77;
    @(posedge CLK);
    nReset <= 1'b1;
    #0.001 chk_both("coincident_release", 1'b0, RV8);
    @(posedge CLK);
    #0.001 chk_both("capture_after_coincident", 1'b1, 8'h77);

    // Randomized phase against the model: after an edge Q is D if reset was high, else the reset value
    for (int i = 0; i < 300; i++) begin
      logic r;
      @(negedge CLK);
      r      = ($urandom_range(0, 4) != 0);
      d1     = 1'($urandom);
      d8     = 8'($urandom);
      nReset = r;
      exp1   = r ? d1 : 1'b0;
      exp8   = r ? d8 : RV8;
      cmp_en = 1'b1;
      if (r && ($urandom_range(0, 7) == 0)) begin
        @(posedge CLK);
        #2 nReset = 1'b0;
        #0.020 nReset = 1'b1;
        #0.001 chk_both("rand_pulse", 1'b0, RV8);
      end
    end
    @(negedge CLK);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_ff1.md
Name: d_ff1

Overview:
- Positive-edge-triggered D flip-flop with asynchronous active-low clear.
- Basic storage primitive for registering single-bit control/status signals. Wider register stages are built as vectors via a width parameter.
- Pure sequential element: no combinational path from D to Q.

Parameters:
- WIDTH, 1, bit width of D and Q.
- RESET_VALUE, all-zeros ('0), value loaded into Q while nReset is low; WIDTH bits.

Ports:
- CLK  input  1  clock; Q samples D on the rising edge.
- nReset  input  1  reset; asynchronous and active-low, forces Q to RESET_VALUE.
- D  input  WIDTH  data to be captured.
- Q  output  WIDTH  registered data.
- Declaration order is fixed as Q, D, CLK, nReset. Existing instances connect positionally.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (nReset). All state is in the single CLK domain.
- Rising CLK edge with nReset high: Q <= D. Latency is one edge: Q reflects D sampled at that edge, settled before the next falling edge.
- Falling CLK edge: no effect.
- D changes between rising edges: no effect on Q until the next rising edge.
- nReset falling: Q = RESET_VALUE immediately, independent of CLK. No clock edge is required.
- nReset held low: Q stays RESET_VALUE through any number of rising edges, whatever D is.
- nReset rising between clock edges: Q keeps RESET_VALUE until the next rising CLK edge, which captures D normally.
- nReset rising coincident with a CLK rising edge: reset wins for that edge, so Q = RESET_VALUE. Capture resumes on the following edge.
- Short reset pulse, e.g. 20 ps low mid-cycle: Q must be RESET_VALUE when nReset returns high. No minimum pulse width is imposed in RTL.
- Power-up before any reset or edge: Q is unknown (X in simulation). No initial-value assignment is allowed.
- Implementation: single always_ff on posedge CLK or negedge nReset, with non-blocking assignment.

Decomposition:
- No shared package. No typedefs are needed; RESET_VALUE is a parameter, not a package constant.
- No sub-module. The block is a leaf cell, instantiated directly or in generate loops by parents.

Test Plan:
- Capture 1: reset released (nReset=1), D=0 initially. Set D=1 on negedge CLK -> 1 ps after the next posedge, Q=1.
- Capture 0: from Q=1, set D=0 on negedge -> 1 ps after the next posedge, Q=0.
- Asynchronous clear pulse: with Q=1 and D=1, 20 ps after posedge drive nReset=0 for 20 ps, then release -> Q=0 1 ps after release, with no clock edge in between.
- Held reset blocks capture: on negedge set nReset=0 and D=1 -> 1 ps after the next posedge, Q=0. Q stays 0 for three further edges.
- Reset release resumes capture: release nReset mid-cycle with D=1 -> Q stays 0 until the next posedge, then Q=1. Also release coincident with posedge -> Q=0 for that edge.
- Parameter check: WIDTH=8, RESET_VALUE=8'hA5 -> reset gives Q=8'hA5; with D=8'h3C, a posedge gives Q=8'h3C.
